// File: rtl/serial_slave_port.sv
// serial_slave_port
// -----------------------------------------------------------------------------
// Bus-side responder for one slot of the serial system bus. It collects an
// LSB-first address (and, for writes, LSB-first data) from the master, performs
// a single access on the local parallel memory port, and for reads shifts the
// memory word back onto the bus LSB first.
//
// Ports
//   clk        system clock, all logic on posedge
//   rstn       synchronous active-low reset
//   swdata     serial address/write-data bit from the bus
//   smode      1 = write, 0 = read; sampled with the first address bit only
//   mvalid     swdata strobe, one bit per asserted cycle
//   srdata     serial read-data bit to the bus (0 when svalid is low)
//   svalid     srdata strobe
//   sready     port idle and able to accept a new frame
//   mem_addr   memory address (capture register)
//   mem_wdata  memory write data (capture register)
//   mem_wen    one-cycle write strobe
//   mem_ren    one-cycle read strobe; mem_rdata is valid the following cycle
//   mem_rdata  memory read data, one-cycle registered latency
//   err        one-cycle pulse when a frame is aborted on timeout
//   dbg_state  current FSM state, for observation only
//
// Handshake: a frame starts only on a cycle where mvalid=1 and sready=1.
// Inside the address/data phases every mvalid cycle carries exactly one bit and
// cycles without mvalid carry nothing. svalid marks each srdata bit; the master
// has no back-pressure on the read stream. mvalid is ignored whenever sready=0
// outside the address/data phases.
// -----------------------------------------------------------------------------
module serial_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_MEMWR = 3'd3;
    localparam logic [2:0] S_MEMRD = 3'd4;
    localparam logic [2:0] S_RWAIT = 3'd5;
    localparam logic [2:0] S_RDATA = 3'd6;

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW);
    localparam int GW   = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT - 1);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  mode_q, mode_d;
    logic                  hold_q, hold_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gap_d    = gap_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shift_d  = shift_q;
        mode_d   = mode_q;
        hold_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // hold_q blocks the single turnaround cycle after a write.
                if (mvalid && !hold_q) begin
                    // LSB-first bits enter at the top and shift down; after
                    // ADDR_WIDTH shifts the register holds the full address.
                    addr_d   = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    mode_d   = smode;
                    bitcnt_d = CNT_ONE;
                    gap_d    = '0;
                    state_d  = S_ADDR;
                end
            end

            S_ADDR: begin
                if (mvalid) begin
                    gap_d  = '0;
                    addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    if (bitcnt_q == ADDR_LAST) begin
                        bitcnt_d = '0;
                        state_d  = mode_q ? S_WDATA : S_MEMRD;
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_ONE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    gap_d    = '0;
                    bitcnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            S_WDATA: begin
                if (mvalid) begin
                    gap_d   = '0;
                    wdata_d = {swdata, wdata_q[DATA_WIDTH-1:1]};
                    if (bitcnt_q == DATA_LAST) begin
                        bitcnt_d = '0;
                        state_d  = S_MEMWR;
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_ONE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    gap_d    = '0;
                    bitcnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            S_MEMWR: begin
                // One idle turnaround cycle follows every write, so sready
                // returns two cycles after the last data bit.
                hold_d  = 1'b1;
                state_d = S_IDLE;
            end

            S_MEMRD: begin
                state_d = S_RWAIT;
            end

            S_RWAIT: begin
                shift_d  = mem_rdata;
                bitcnt_d = '0;
                state_d  = S_RDATA;
            end

            S_RDATA: begin
                shift_d = shift_q >> 1;
                if (bitcnt_q == DATA_LAST) begin
                    bitcnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            gap_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
            mode_q   <= 1'b0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gap_q    <= gap_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shift_q  <= shift_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    // Every output is decoded from registered state only.
    assign sready    = (state_q == S_IDLE) && !hold_q;
    assign svalid    = (state_q == S_RDATA);
    assign srdata    = svalid & shift_q[0];
    assign mem_wen   = (state_q == S_MEMWR);
    assign mem_ren   = (state_q == S_MEMRD);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_slave_port.sv
module tb_serial_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk;
  logic          rstn;
  logic          swdata;
  logic          smode;
  logic          mvalid;
  logic          srdata;
  logic          svalid;
  logic          sready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          err;
  logic [2:0]    dbg_state;

  int n_checks;
  int n_fail;
  int wen_cnt;
  int ren_cnt;
  int err_cnt;

  // memory model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  serial_slave_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .swdata(swdata),
    .smode(smode),
    .mvalid(mvalid),
    .srdata(srdata),
    .svalid(svalid),
    .sready(sready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wen(mem_wen),
    .mem_ren(mem_ren),
    .mem_rdata(mem_rdata),
    .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  // strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (err)     err_cnt <= err_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    swdata = b;
    mvalid = 1'b1;
    step();
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  task automatic send_frame(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    smode = wr;
    for (int i = 0; i < AW; i++) begin
      if (i > 0) repeat (gap) step();
      send_bit(a[i]);
    end
    if (wr) begin
      for (int i = 0; i < DW; i++) begin
        repeat (gap) step();
        send_bit(d[i]);
      end
    end
    smode = 1'b0;
  endtask

  // full write frame with timing checks; spur holds mvalid high through MEMWR
  // and the turnaround cycle
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap, input bit spur);
    int w0, r0, e0;
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    send_frame(1'b1, a, d, gap);
    if (spur) begin mvalid = 1'b1; swdata = 1'b1; end
    check("wr_wen_T", mem_wen, 1);
    check("wr_addr", mem_addr, a);
    check("wr_wdata", mem_wdata, d);
    check("wr_sready_T", sready, 0);
    step();
    check("wr_wen_T1", mem_wen, 0);
    check("wr_sready_T1", sready, 0);
    step();
    mvalid = 1'b0; swdata = 1'b0;
    check("wr_sready_T2", sready, 1);
    step();
    check("wr_sready_T3", sready, 1);
    check("wr_wen_count", wen_cnt - w0, 1);
    check("wr_ren_count", ren_cnt - r0, 0);
    check("wr_err_count", err_cnt - e0, 0);
  endtask

  // full read frame with timing checks; spur holds mvalid high from MEMRD
  // through the cycle that returns to IDLE
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int gap, input bit spur);
    int w0, r0, e0;
    logic [DW-1:0] rd;
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    rd = '0;
    send_frame(1'b0, a, '0, gap);
    if (spur) begin mvalid = 1'b1; swdata = 1'b1; end
    check("rd_ren_T", mem_ren, 1);
    check("rd_addr", mem_addr, a);
    check("rd_svalid_T", svalid, 0);
    step();
    check("rd_ren_T1", mem_ren, 0);
    check("rd_svalid_T1", svalid, 0);
    for (int i = 0; i < DW; i++) begin
      step();
      check("rd_svalid_bit", svalid, 1);
      rd[i] = srdata;
    end
    step();
    mvalid = 1'b0; swdata = 1'b0;
    check("rd_svalid_end", svalid, 0);
    check("rd_sready_end", sready, 1);
    check("rd_data", rd, exp);
    step();
    check("rd_sready_after", sready, 1);
    check("rd_ren_count", ren_cnt - r0, 1);
    check("rd_wen_count", wen_cnt - w0, 0);
    check("rd_err_count", err_cnt - e0, 0);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;   // write data, or expected read data
    int            gap;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w0, r0, e0;
    n_checks = 0; n_fail = 0;
    wen_cnt = 0; ren_cnt = 0; err_cnt = 0;

    vecs[0] = '{wr: 1'b0, addr: 12'h005, data: 8'h3C, gap: 0};
    vecs[1] = '{wr: 1'b1, addr: 12'h005, data: 8'hA5, gap: 0};
    vecs[2] = '{wr: 1'b0, addr: 12'h005, data: 8'hA5, gap: 0};
    vecs[3] = '{wr: 1'b1, addr: 12'hFFF, data: 8'h81, gap: 3};
    vecs[4] = '{wr: 1'b0, addr: 12'hFFF, data: 8'h81, gap: 2};
    vecs[5] = '{wr: 1'b1, addr: 12'h800, data: 8'h01, gap: 1};
    vecs[6] = '{wr: 1'b0, addr: 12'h800, data: 8'h01, gap: 0};

    rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0;
    load_en = 1'b1; load_addr = 12'h005; load_data = 8'h3C;
    repeat (3) step();
    load_en = 1'b0;

    check("rst_sready", sready, 1);
    check("rst_svalid", svalid, 0);
    check("rst_srdata", srdata, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    step();
    check("rst_sready_rel", sready, 1);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].gap, 1'b0);
      else            do_read(vecs[v].addr, vecs[v].data, vecs[v].gap, 1'b0);
    end

    // timeout: 5 address bits, then silence
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    smode = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    smode = 1'b0;
    repeat (TO - 1) step();
    check("to_err_before", err, 0);
    check("to_sready_before", sready, 0);
    check("to_err_cnt_before", err_cnt - e0, 0);
    step();
    check("to_err_at", err, 1);
    check("to_sready_at", sready, 1);
    step();
    check("to_err_after", err, 0);
    check("to_err_count", err_cnt - e0, 1);
    check("to_wen_count", wen_cnt - w0, 0);
    check("to_ren_count", ren_cnt - r0, 0);
    do_write(12'h001, 8'h55, 0, 1'b0);
    do_read(12'h001, 8'h55, 0, 1'b0);

    // reset during the third RDATA cycle
    r0 = ren_cnt;
    send_frame(1'b0, 12'h005, '0, 0);
    step();
    step();
    step();
    step();
    check("rr_svalid_3rd", svalid, 1);
    rstn = 1'b0;
    step();
    check("rr_svalid_rst", svalid, 0);
    check("rr_sready_rst", sready, 1);
    check("rr_ren_rst", mem_ren, 0);
    rstn = 1'b1;
    step();
    check("rr_sready_rel", sready, 1);
    check("rr_svalid_rel", svalid, 0);
    repeat (3) step();
    check("rr_ren_count", ren_cnt - r0, 1);
    check("rr_state_idle", dbg_state, 0);

    // spurious mvalid during MEMWR/turnaround and during RDATA
    do_write(12'h123, 8'h3C, 0, 1'b1);
    do_read(12'h123, 8'h3C, 0, 1'b1);
    do_read(12'hFFF, 8'h81, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Bus-side responder for the serial system bus. It deserializes the bit-serial address and write data that a master interface drives through the bus. It performs one access on a local parallel memory port, and for reads it serializes the data back to the bus. It sits between a serial bus slave slot (s*_wdata/mode/wvalid/rvalid/rdata/ready) and a slave's memory array, replacing ad-hoc deserializers in each slave.

## Interface
- ADDR_WIDTH, 12, slave memory address bits carried on the bus (must be >= 2)
- DATA_WIDTH, 8, data word bits (must be >= 2)
- TIMEOUT, 64, cycles without mvalid mid-frame before the frame is aborted
- clk  input  1  system clock; all logic on posedge
- rstn  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- swdata  input  1  serial address/write-data bit from bus
- smode  input  1  1 = write, 0 = read; sampled with first address bit only
- mvalid  input  1  swdata valid strobe, one bit per asserted cycle
- srdata  output  1  serial read-data bit to bus
- svalid  output  1  srdata valid strobe
- sready  output  1  port idle and able to accept a new frame
- mem_addr  output  ADDR_WIDTH  memory address, held from end of address phase until next frame
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_wen  output  1  one-cycle write strobe
- mem_ren  output  1  one-cycle read strobe; mem_rdata valid the following cycle
- mem_rdata  input  DATA_WIDTH  memory read data, 1-cycle registered latency
- err  output  1  one-cycle pulse on frame timeout abort

## Operation
- States: IDLE, ADDR, WDATA, MEMWR, MEMRD, RWAIT, RDATA.
- Bit order on the serial lines is LSB first for both address and data.
- IDLE, sready=1:
  - On mvalid: store swdata as addr[0], latch smode, bitcnt=1, go to ADDR.
- ADDR:
  - Each mvalid cycle: addr[bitcnt]=swdata and bitcnt++.
  - On the bit with bitcnt==ADDR_WIDTH-1: go to WDATA (write, bitcnt=0) or MEMRD (read).
- WDATA:
  - Each mvalid cycle: wdata[bitcnt]=swdata.
  - After the DATA_WIDTH-th bit: go to MEMWR.
- MEMWR: mem_wen=1 for exactly one cycle, then IDLE.
- MEMRD: mem_ren=1 for exactly one cycle, then RWAIT.
- RWAIT: load mem_rdata into the shift register, bitcnt=0, go to RDATA.
- RDATA:
  - svalid=1 and srdata=shift[0]; shift right each cycle.
  - After DATA_WIDTH cycles: IDLE.
- mvalid gaps are legal in ADDR and WDATA; bits shift only on mvalid cycles.
- Timeout:
  - gapcnt clears on every mvalid and increments on every cycle without mvalid, in ADDR/WDATA only.
  - On reaching TIMEOUT: go to IDLE, pulse err, issue no memory access.
- mvalid outside IDLE/ADDR/WDATA is ignored; it does not start a new frame.
- mem_addr and mem_wdata are outputs of the capture registers; their values are don't-care outside MEMWR/MEMRD.

## Timing
- Reset: state=IDLE, bitcnt=0, gapcnt=0, shift/addr/wdata=0.
  - Outputs after reset: sready=1; svalid=0, srdata=0, mem_wen=0, mem_ren=0, err=0, mem_addr=0, mem_wdata=0.
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- Write frame, last data bit sampled at edge T:
  - mem_wen high in cycle T..T+1.
  - sready high from T+2.
  - Minimum frame is ADDR_WIDTH+DATA_WIDTH+2 cycles.
- Read frame, last address bit sampled at edge T:
  - mem_ren high T..T+1.
  - RWAIT T+1..T+2.
  - svalid high for DATA_WIDTH consecutive cycles starting T+2.
  - sready high DATA_WIDTH cycles after svalid rises.
- Timeout: err rises exactly TIMEOUT cycles after the last mvalid; sready rises in the same cycle.
- rstn low in any state: return to IDLE at the next edge.
  - Any in-flight mem_wen/mem_ren/svalid drops.
  - No partial write is ever issued.
- mvalid in the same cycle that MEMWR/RDATA returns to IDLE is ignored; a new frame needs mvalid while sready=1.

## Test plan
- Write, no gaps: addr 0x005, data 0xA5 (ADDR_WIDTH=12, DATA_WIDTH=8) -> exactly one mem_wen pulse with mem_addr=0x005, mem_wdata=0xA5; sready returns 2 cycles after the last bit.
- Read: memory model holds 0x3C at 0x005; read frame addr 0x005 -> one mem_ren; svalid high 8 consecutive cycles with srdata 0,0,1,1,1,1,0,0; then sready=1.
- Gapped write: address 0xFFF, data 0x81, with 3 idle cycles between every bit (gap < TIMEOUT) -> single write, mem_addr=0xFFF, mem_wdata=0x81, err stays 0.
- Timeout: 5 address bits then mvalid held low -> err pulses once TIMEOUT=64 cycles after the 5th bit; no mem_wen or mem_ren; the next full write frame to 0x001/0x55 completes correctly.
- Reset mid-read: rstn low during the 3rd RDATA cycle -> svalid=0 next cycle and sready=1 after reset release; no extra mem_ren.
- Spurious mvalid during RDATA and MEMWR -> no state change, no extra memory strobes; the frame completes unchanged.
